// File: rtl/imm_extend_pipe_pkg.sv
// rtl/imm_extend_pipe_pkg.sv - shared constants for the immediate extender
//
// Purpose: extension-mode encodings and the standard shift amounts the decoder
//          uses when scaling branch and word load/store offsets.
package imm_ext_pkg;

  // Extension mode carried with every immediate.
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  // Standard scaling shifts: branch targets and word LD/ST offsets.
  localparam int SHIFT_BRANCH = 1;
  localparam int SHIFT_WORD   = 1;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - operand handshake bundle between decoder and extender
//
// Purpose: groups the input (decoder side) and output (operand mux side)
//          valid/ready channels of imm_extend_pipe.
// Signals:
//   in_valid/in_ready  input item handshake
//   in_data            raw instruction field
//   in_msb             index of the field's top bit
//   in_shift           left-shift amount
//   in_mode            EXT_ZERO / EXT_SIGN
//   out_valid/out_ready result handshake
//   out_data           extended and shifted value
//   out_ovf            significant bits lost by the shift
interface imm_extend_pipe_if #(
  parameter int DATA_W    = 16,
  parameter int MAX_SHIFT = 3
);
  import imm_ext_pkg::*;

  localparam int MSB_W   = $clog2(DATA_W);
  localparam int SHIFT_W = $clog2(MAX_SHIFT + 1);

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [MSB_W-1:0]   in_msb;
  logic [SHIFT_W-1:0] in_shift;
  logic               in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_ovf;

  // Producer/consumer side (decoder and operand mux).
  modport master (
    output in_valid, in_data, in_msb, in_shift, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  // The extender itself.
  modport slave (
    input  in_valid, in_data, in_msb, in_shift, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/imm_extend_pipe_ext_core.sv
// rtl/imm_extend_pipe_ext_core.sv - combinational mask-and-extend of an immediate field
//
// Purpose: clears bits above msb, then sign-extends from msb when mode is EXT_SIGN.
// Ports:
//   data  in   DATA_W  raw field
//   msb   in   MSB_W   index of the field's top bit
//   mode  in   1       EXT_ZERO / EXT_SIGN
//   ext   out  DATA_W  masked and extended value
module ext_core #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]         data,
  input  logic [$clog2(DATA_W)-1:0] msb,
  input  logic                      mode,
  output logic [DATA_W-1:0]         ext
);
  import imm_ext_pkg::*;

  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] field;

  always_comb begin
    // 2 << msb wraps to zero at msb = DATA_W-1, so the subtraction yields all ones.
    mask  = (DATA_W'(2) << msb) - DATA_W'(1);
    field = data & mask;
    if (mode == EXT_SIGN && field[msb]) begin
      ext = field | ({DATA_W{1'b1}} << msb);
    end else begin
      ext = field;
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - two-stage pipelined immediate extender with shift and overflow flag
//
// Purpose: stage 1 masks/extends the raw field, stage 2 left-shifts it and flags
//          lost significant bits; valid/ready flow control on both sides.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  asynchronous active-high reset
//   flush  in  synchronous pipeline clear (branch redirect), wins over every advance
//   bus    imm_extend_pipe_if.slave  input and output handshakes
module imm_extend_pipe #(
  parameter int DATA_W    = 16,
  parameter int MAX_SHIFT = 3
) (
  input logic              clk,
  input logic              rst,
  input logic              flush,
  imm_extend_pipe_if.slave bus
);
  import imm_ext_pkg::*;

  localparam int SHIFT_W = $clog2(MAX_SHIFT + 1);

  logic               s1_valid;
  logic [DATA_W-1:0]  s1_ext;
  logic [SHIFT_W-1:0] s1_shift;
  logic               s1_mode;
  logic               s2_valid;
  logic [DATA_W-1:0]  s2_data;
  logic               s2_ovf;

  logic               s2_adv;
  logic               s1_adv;
  logic               accept;
  logic [DATA_W-1:0]  ext_w;
  logic [SHIFT_W-1:0] shift_clamped;
  logic [DATA_W-1:0]  shl;
  logic               ovf_w;

  // Handshake: each stage may refill in the same cycle it drains.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = s1_valid && s2_adv;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_ovf   = s2_ovf;

  ext_core #(.DATA_W(DATA_W)) u_ext_core (
    .data (bus.in_data),
    .msb  (bus.in_msb),
    .mode (bus.in_mode),
    .ext  (ext_w)
  );

  // Out-of-range shift codes only exist when MAX_SHIFT+1 is not a power of two.
  if ((2 ** SHIFT_W) - 1 > MAX_SHIFT) begin : g_clamp
    assign shift_clamped = (bus.in_shift > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT)
                                                                : bus.in_shift;
  end else begin : g_no_clamp
    assign shift_clamped = bus.in_shift;
  end

  // Shifting back and comparing detects lost bits: arithmetic for sign mode
  // (top shift+1 bits must agree), logical for zero mode (top shift bits zero).
  always_comb begin
    shl = s1_ext << s1_shift;
    if (s1_mode == EXT_SIGN) begin
      ovf_w = ($signed(shl) >>> s1_shift) != $signed(s1_ext);
    end else begin
      ovf_w = (shl >> s1_shift) != s1_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      // in_ready means stage 1 is empty or leaving, so it just takes in_valid.
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (s2_adv)       s2_valid <= s1_valid;
    end
  end

  // Data registers are left untouched by flush; only the valids are cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_ext   <= '0;
      s1_shift <= '0;
      s1_mode  <= EXT_ZERO;
    end else if (accept && !flush) begin
      s1_ext   <= ext_w;
      s1_shift <= shift_clamped;
      s1_mode  <= bus.in_mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_data <= '0;
      s2_ovf  <= 1'b0;
    end else if (s1_adv && !flush) begin
      s2_data <= shl;
      s2_ovf  <= ovf_w;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - scoreboard bench for imm_extend_pipe
module tb_imm_extend_pipe;
  import imm_ext_pkg::*;

  localparam int DW = 16;
  localparam int MS = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.DATA_W(DW), .MAX_SHIFT(MS)) bus ();

  imm_extend_pipe #(.DATA_W(DW), .MAX_SHIFT(MS)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  // Directed cases with hand-derived results.
  logic [15:0] t_d  [8] = '{16'h0080, 16'hFE00, 16'hFE00, 16'hFFFF, 16'h4000, 16'h0001, 16'hF000, 16'hE000};
  int          t_m  [8] = '{7, 9, 9, 7, 15, 15, 15, 15};
  int          t_s  [8] = '{0, 1, 1, 0, 1, 3, 3, 2};
  logic        t_md [8] = '{EXT_SIGN, EXT_SIGN, EXT_ZERO, EXT_ZERO, EXT_SIGN, EXT_ZERO, EXT_ZERO, EXT_SIGN};
  logic [15:0] t_ed [8] = '{16'hFF80, 16'hFC00, 16'h0400, 16'h00FF, 16'h8000, 16'h0008, 16'h8000, 16'h8000};
  logic        t_eo [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  // Reference: treat the field as an integer, scale by 2**shift, and flag
  // results that no longer fit a DW-bit signed (sign mode) or unsigned word.
  function automatic exp_t model(input logic [15:0] d, input int msb, input int sh, input logic mode);
    exp_t   e;
    longint w = msb + 1;
    longint f = longint'(d) & ((longint'(1) << w) - 1);
    longint v = f;
    longint r;
    if (mode == EXT_SIGN && ((f >> msb) & 1) == 1) v = f - (longint'(1) << w);
    r = v * (longint'(1) << sh);
    e.data = r[15:0];
    if (mode == EXT_SIGN) e.ovf = (r < -32768) || (r > 32767);
    else                  e.ovf = (r > 65535);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One cycle of stimulus; pushes the expected result when the item is accepted.
  task automatic drive_cycle(input logic v, input logic [15:0] d, input int msb, input int sh,
                             input logic mode, input logic ordy, input logic fl,
                             input logic use_ex, input exp_t ex, output logic acc);
    @(negedge clk);
    if (fl) ordy = 1'b0;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_msb    = 4'(msb);
    bus.in_shift  = 2'(sh);
    bus.in_mode   = mode;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    acc = v && bus.in_ready && !fl;
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(use_ex ? ex : model(d, msb, sh, mode));
  endtask

  task automatic idle(input logic ordy);
    logic a;
    exp_t z;
    z.data = '0;
    z.ovf  = 1'b0;
    drive_cycle(1'b0, 16'h0, 0, 0, EXT_ZERO, ordy, 1'b0, 1'b0, z, a);
  endtask

  task automatic send_lat(input logic [15:0] d, input int msb, input int sh, input logic mode,
                          input logic use_ex, input exp_t ex);
    logic a;
    drive_cycle(1'b1, d, msb, sh, mode, 1'b1, 1'b0, use_ex, ex, a);
    check("lat_accept", a, 1);
    idle(1'b1);
    check("lat_early_valid", bus.out_valid, 0);
    idle(1'b1);
    check("lat_due_valid", bus.out_valid, 1);
  endtask

  // Monitor: pops and compares on every output transfer, checks hold stability.
  initial begin
    logic          hold;
    logic [DW-1:0] hd;
    logic          ho;
    exp_t          e;
    hold = 1'b0;
    hd   = '0;
    ho   = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold && bus.out_valid) begin
          check("hold_data", bus.out_data, hd);
          check("hold_ovf", bus.out_ovf, ho);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_output: got %0h, required no output", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_ovf", bus.out_ovf, e.ovf);
          end
        end
        hold = bus.out_valid && !bus.out_ready && !flush;
        hd   = bus.out_data;
        ho   = bus.out_ovf;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    exp_t        ex;
    exp_t        item0;
    int          idx;
    logic [15:0] bp_d [4] = '{16'h1111, 16'h8222, 16'h0333, 16'hF444};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_msb    = '0;
    bus.in_shift  = '0;
    bus.in_mode   = EXT_ZERO;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    rst           = 1'b1;

    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_ovf", bus.out_ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    // Directed extension/shift/overflow cases with latency check.
    for (int i = 0; i < 8; i++) begin
      ex.data = t_ed[i];
      ex.ovf  = t_eo[i];
      send_lat(t_d[i], t_m[i], t_s[i], t_md[i], 1'b1, ex);
    end
    idle(1'b1);

    // Backpressure: two accepts, then stall with item 0 held on the output.
    item0 = model(bp_d[0], 15, 0, EXT_SIGN);
    idx = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      drive_cycle(idx < 4, (idx < 4) ? bp_d[idx % 4] : 16'h0, 15, idx % 4, EXT_SIGN,
                  cyc >= 4, 1'b0, 1'b0, ex, acc);
      if (cyc < 2) check("bp_accept", acc, 1);
      if (cyc == 2 || cyc == 3) begin
        check("bp_stall_in_ready", bus.in_ready, 0);
        check("bp_hold_item0", bus.out_data, item0.data);
      end
      if (acc) idx++;
    end
    check("bp_all_accepted", idx, 4);
    check("bp_drained", exp_q.size(), 0);

    // Flush with both stages full; the item offered during flush must vanish.
    drive_cycle(1'b1, 16'h1234, 15, 1, EXT_ZERO, 1'b0, 1'b0, 1'b0, ex, acc);
    drive_cycle(1'b1, 16'h5678, 15, 1, EXT_ZERO, 1'b0, 1'b0, 1'b0, ex, acc);
    drive_cycle(1'b1, 16'h9ABC, 15, 1, EXT_ZERO, 1'b0, 1'b1, 1'b0, ex, acc);
    idle(1'b1);
    check("flush_full_valid", bus.out_valid, 0);
    for (int k = 0; k < 4; k++) idle(1'b1);

    // Flush with stage 1 only: in_ready is high, yet the offered item is dropped.
    drive_cycle(1'b1, 16'h0F0F, 15, 0, EXT_ZERO, 1'b0, 1'b0, 1'b0, ex, acc);
    drive_cycle(1'b1, 16'h7777, 15, 0, EXT_ZERO, 1'b0, 1'b1, 1'b0, ex, acc);
    check("flush_in_ready", bus.in_ready, 1);
    idle(1'b1);
    check("flush_s1_valid", bus.out_valid, 0);
    for (int k = 0; k < 4; k++) idle(1'b1);
    check("flush_queue_empty", exp_q.size(), 0);

    // Asynchronous reset between edges with the pipeline full.
    drive_cycle(1'b1, 16'h00AA, 7, 2, EXT_SIGN, 1'b0, 1'b0, 1'b0, ex, acc);
    drive_cycle(1'b1, 16'h0055, 7, 2, EXT_SIGN, 1'b0, 1'b0, 1'b0, ex, acc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_valid", bus.out_valid, 0);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("rst_release_in_ready", bus.in_ready, 1);
    send_lat(16'h00AA, 7, 2, EXT_SIGN, 1'b0, ex);
    idle(1'b1);

    // Randomised traffic with random backpressure and occasional flush.
    for (int n = 0; n < 600; n++) begin
      drive_cycle(($urandom % 4) != 0, 16'($urandom), $urandom % 16, $urandom % 4,
                  1'($urandom % 2), ($urandom % 4) != 0, ($urandom % 50) == 0,
                  1'b0, ex, acc);
    end
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1'b1);
    check("final_drain", exp_q.size(), 0);
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
